// File: rtl/pattern_video_source_pkg.sv
// Shared project package: raster geometry, field widths, the run-state
// enumeration and the settings bundle that is latched once per frame.
package pattern_video_source_pkg;

    localparam int IMAGE_W      = 320;
    localparam int IMAGE_H      = 240;
    localparam int X_WIDTH      = 9;
    localparam int Y_WIDTH      = 8;
    localparam int COLOUR_WIDTH = 3;
    localparam int POS_WIDTH    = 10;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        PACE,
        FRAME_END
    } state_t;

    // Everything the raster needs to stay constant for a whole frame.
    typedef struct packed {
        logic [3:0]              paceDiv;
        logic [5:0]              objSize;
        logic [2:0]              speed;
        logic [COLOUR_WIDTH-1:0] objColour;
        logic [COLOUR_WIDTH-1:0] bgColour;
    } settings_t;

    // True when coord lies in the half-open span [pos, pos+size).
    // A size of zero yields an empty span, which is how "no object" works.
    function automatic logic insideSpan(
        input logic [POS_WIDTH-1:0] coord,
        input logic [POS_WIDTH-1:0] pos,
        input logic [5:0]           size
    );
        logic [POS_WIDTH-1:0] spanEnd;
        spanEnd = pos + POS_WIDTH'(size);
        return (coord >= pos) && (coord < spanEnd);
    endfunction

endpackage

// File: rtl/pattern_video_source_if.sv
// Pixel stream between the pattern source and its sink: one strobe per
// pixel with coordinates and colour, plus a stall line from the sink.
interface pattern_video_source_if;
    import pattern_video_source_pkg::*;

    logic                    waitrequest;
    logic                    pixel_en;
    logic [X_WIDTH-1:0]      x;
    logic [Y_WIDTH-1:0]      y;
    logic [COLOUR_WIDTH-1:0] colour;
    logic                    frame_start;

    modport master (
        input  waitrequest,
        output pixel_en,
        output x,
        output y,
        output colour,
        output frame_start
    );

    modport slave (
        output waitrequest,
        input  pixel_en,
        input  x,
        input  y,
        input  colour,
        input  frame_start
    );

endinterface

// File: rtl/pattern_video_source_bounce_axis.sv
// One axis of the bouncing object: the position moves by speed once per
// frame and reverses when the object would cross 0 or LIMIT.
module bounce_axis #(
    parameter int LIMIT = 320
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_update,
    input  logic [5:0] i_size,
    input  logic [2:0] i_speed,
    output logic [9:0] o_pos
);
    import pattern_video_source_pkg::*;

    localparam logic [POS_WIDTH-1:0] W_LIMIT = POS_WIDTH'(LIMIT);

    logic [POS_WIDTH-1:0] r_pos;
    logic                 r_dirNeg;
    logic [POS_WIDTH-1:0] w_speed;
    logic [POS_WIDTH-1:0] w_size;
    logic [POS_WIDTH-1:0] w_farEdge;

    assign w_speed   = POS_WIDTH'(i_speed);
    assign w_size    = POS_WIDTH'(i_size);
    assign w_farEdge = r_pos + w_speed + w_size;
    assign o_pos     = r_pos;

    // Advance once per update strobe, clamping to the wall and flipping direction on contact.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pos    <= '0;
            r_dirNeg <= 1'b0;
        end else if (i_update) begin
            if (!r_dirNeg) begin
                if (w_farEdge > W_LIMIT) begin
                    r_pos    <= W_LIMIT - w_size;
                    r_dirNeg <= 1'b1;
                end else begin
                    r_pos <= r_pos + w_speed;
                end
            end else begin
                if (r_pos < w_speed) begin
                    r_pos    <= '0;
                    r_dirNeg <= 1'b0;
                end else begin
                    r_pos <= r_pos - w_speed;
                end
            end
        end
    end

endmodule

// File: rtl/pattern_video_source.sv
// Test-pattern generator: walks the raster in x-major order, paints a
// bouncing square over a flat background and emits one registered pixel
// per strobe, honouring sink stalls and an optional inter-pixel gap.
module pattern_video_source #(
    parameter int IMAGE_W = pattern_video_source_pkg::IMAGE_W,
    parameter int IMAGE_H = pattern_video_source_pkg::IMAGE_H
) (
    input  logic                                          clock,
    input  logic                                          resetn,
    input  logic                                          enable,
    input  logic [3:0]                                    pace_div,
    input  logic [5:0]                                    obj_size,
    input  logic [2:0]                                    speed,
    input  logic [pattern_video_source_pkg::COLOUR_WIDTH-1:0] obj_colour,
    input  logic [pattern_video_source_pkg::COLOUR_WIDTH-1:0] bg_colour,
    output logic [15:0]                                   frame_count,
    pattern_video_source_if.master                        vid
);
    import pattern_video_source_pkg::*;

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(IMAGE_W - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(IMAGE_H - 1);

    state_t                  r_state;
    state_t                  w_nextState;
    settings_t               r_set;
    logic [3:0]              r_paceCnt;
    logic [X_WIDTH-1:0]      r_cntX;
    logic [Y_WIDTH-1:0]      r_cntY;

    logic                    r_pixelEn;
    logic [X_WIDTH-1:0]      r_x;
    logic [Y_WIDTH-1:0]      r_y;
    logic [COLOUR_WIDTH-1:0] r_colour;
    logic                    r_frameStart;
    logic [15:0]             r_frameCount;

    logic                    w_emit;
    logic                    w_latch;
    logic                    w_frameEnd;
    logic                    w_paceLoad;
    logic                    w_lastPixel;
    logic                    w_inObj;
    logic [POS_WIDTH-1:0]    w_objX;
    logic [POS_WIDTH-1:0]    w_objY;

    assign w_lastPixel = (r_cntX == X_LAST) && (r_cntY == Y_LAST);
    assign w_inObj     = insideSpan(POS_WIDTH'(r_cntX), w_objX, r_set.objSize)
                       && insideSpan(POS_WIDTH'(r_cntY), w_objY, r_set.objSize);

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; the last pixel takes priority over pacing.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_nextState = EMIT;
                end
            end
            EMIT: begin
                if (!vid.waitrequest) begin
                    if (w_lastPixel) begin
                        w_nextState = FRAME_END;
                    end else if (r_set.paceDiv != 4'd0) begin
                        w_nextState = PACE;
                    end
                end
            end
            PACE: begin
                if (r_paceCnt == 4'd0) begin
                    w_nextState = EMIT;
                end
            end
            FRAME_END: begin
                w_nextState = enable ? EMIT : IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Control strobes derived from the current state for the datapath below.
    always_comb begin
        w_emit     = 1'b0;
        w_latch    = 1'b0;
        w_frameEnd = 1'b0;
        w_paceLoad = 1'b0;
        case (r_state)
            IDLE:      w_latch = enable;
            EMIT: begin
                w_emit     = !vid.waitrequest;
                w_paceLoad = !vid.waitrequest && !w_lastPixel && (r_set.paceDiv != 4'd0);
            end
            FRAME_END: begin
                w_latch    = 1'b1;
                w_frameEnd = 1'b1;
            end
            default: begin
                w_emit = 1'b0;
            end
        endcase
    end

    // Settings only change between frames so a frame never mixes two configurations.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_set <= '0;
        end else if (w_latch) begin
            r_set <= '{paceDiv:   pace_div,
                       objSize:   obj_size,
                       speed:     speed,
                       objColour: obj_colour,
                       bgColour:  bg_colour};
        end
    end

    // Gap counter: loaded after an emission so PACE lasts exactly paceDiv cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_paceCnt <= '0;
        end else if (w_paceLoad) begin
            r_paceCnt <= r_set.paceDiv - 4'd1;
        end else if ((r_state == PACE) && (r_paceCnt != 4'd0)) begin
            r_paceCnt <= r_paceCnt - 4'd1;
        end
    end

    // Raster walker holding the pending pixel; it parks on the last pixel until the frame closes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cntX <= '0;
            r_cntY <= '0;
        end else if (w_frameEnd) begin
            r_cntX <= '0;
            r_cntY <= '0;
        end else if (w_emit && !w_lastPixel) begin
            if (r_cntX == X_LAST) begin
                r_cntX <= '0;
                r_cntY <= r_cntY + Y_WIDTH'(1);
            end else begin
                r_cntX <= r_cntX + X_WIDTH'(1);
            end
        end
    end

    // Registered pixel outputs; coordinates and colour hold between strobes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pixelEn    <= 1'b0;
            r_frameStart <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
        end else begin
            r_pixelEn    <= w_emit;
            r_frameStart <= w_emit && (r_cntX == '0) && (r_cntY == '0);
            if (w_emit) begin
                r_x      <= r_cntX;
                r_y      <= r_cntY;
                r_colour <= w_inObj ? r_set.objColour : r_set.bgColour;
            end
        end
    end

    // Completed-frame counter, wrapping naturally at 16 bits.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_frameCount <= '0;
        end else if (w_frameEnd) begin
            r_frameCount <= r_frameCount + 16'd1;
        end
    end

    // The object moves with the settings of the frame that just finished.
    bounce_axis #(.LIMIT(IMAGE_W)) u_bounceX (
        .clock    (clock),
        .resetn   (resetn),
        .i_update (w_frameEnd),
        .i_size   (r_set.objSize),
        .i_speed  (r_set.speed),
        .o_pos    (w_objX)
    );

    bounce_axis #(.LIMIT(IMAGE_H)) u_bounceY (
        .clock    (clock),
        .resetn   (resetn),
        .i_update (w_frameEnd),
        .i_size   (r_set.objSize),
        .i_speed  (r_set.speed),
        .o_pos    (w_objY)
    );

    assign vid.pixel_en    = r_pixelEn;
    assign vid.x           = r_x;
    assign vid.y           = r_y;
    assign vid.colour      = r_colour;
    assign vid.frame_start = r_frameStart;
    assign frame_count     = r_frameCount;

endmodule

// File: tb/tb_pattern_video_source.sv
// Bench for pattern_video_source on a reduced 24x16 raster, with a raster
// order/colour model checked every cycle, directed timing checks, and a
// full-size bounce_axis pair pinned against known bounce sequences.
module tb_pattern_video_source;
    import pattern_video_source_pkg::*;

    localparam int W    = 24;
    localparam int H    = 16;
    localparam int NPIX = W * H;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        enable;
    logic [3:0]  paceDiv;
    logic [5:0]  objSize;
    logic [2:0]  speed;
    logic [2:0]  objColour;
    logic [2:0]  bgColour;
    logic [15:0] frameCount;

    logic        bUpdate;
    logic [9:0]  bPosX;
    logic [9:0]  bPosY;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    pattern_video_source_if vidIf();

    pattern_video_source #(.IMAGE_W(W), .IMAGE_H(H)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .enable      (enable),
        .pace_div    (paceDiv),
        .obj_size    (objSize),
        .speed       (speed),
        .obj_colour  (objColour),
        .bg_colour   (bgColour),
        .frame_count (frameCount),
        .vid         (vidIf)
    );

    bounce_axis #(.LIMIT(320)) bounceX (
        .clock    (clock),
        .resetn   (resetn),
        .i_update (bUpdate),
        .i_size   (6'd63),
        .i_speed  (3'd7),
        .o_pos    (bPosX)
    );

    bounce_axis #(.LIMIT(240)) bounceY (
        .clock    (clock),
        .resetn   (resetn),
        .i_update (bUpdate),
        .i_size   (6'd63),
        .i_speed  (3'd7),
        .o_pos    (bPosY)
    );

    // 50 MHz clock
    always #10 clock = ~clock;

    // Cycle counter used for latency and period measurements
    always @(posedge clock) cycle++;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] p, input logic [5:0] sz, input logic [2:0] sp,
                                 input logic [2:0] oc, input logic [2:0] bc, input logic en);
        paceDiv   = p;
        objSize   = sz;
        speed     = sp;
        objColour = oc;
        bgColour  = bc;
        enable    = en;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Bounce rule as stated for the object: clamp at the wall and reverse.
    task automatic bounceStep(inout int pos, inout bit dirNeg, input int limit, input int size, input int spd);
        if (!dirNeg) begin
            if (pos + spd + size > limit) begin
                pos    = limit - size;
                dirNeg = 1'b1;
            end else begin
                pos = pos + spd;
            end
        end else begin
            if (pos < spd) begin
                pos    = 0;
                dirNeg = 1'b0;
            end else begin
                pos = pos - spd;
            end
        end
    endtask

    // Model state: next raster index, completed frames, object position, last emitted pixel
    int mIdx, mFrames, mPosX, mPosY, mLastX, mLastY, mLastC;
    bit mDirNegX, mDirNegY;

    // Every cycle: zero outputs under reset, raster/colour order on strobes, hold otherwise
    always @(negedge clock) begin
        int ex, ey, ec;
        bit inObj;
        if (!resetn) begin
            checkOutput("reset_outputs_zero",
                        {vidIf.pixel_en, vidIf.frame_start, vidIf.x, vidIf.y, vidIf.colour, frameCount}, 0);
            mIdx = 0; mFrames = 0; mPosX = 0; mPosY = 0;
            mDirNegX = 0; mDirNegY = 0;
            mLastX = 0; mLastY = 0; mLastC = 0;
        end else if (vidIf.pixel_en) begin
            ex = mIdx % W;
            ey = mIdx / W;
            inObj = (ex >= mPosX) && (ex < mPosX + int'(objSize)) &&
                    (ey >= mPosY) && (ey < mPosY + int'(objSize));
            ec = inObj ? int'(objColour) : int'(bgColour);
            checkOutput("model_x", vidIf.x, ex);
            checkOutput("model_y", vidIf.y, ey);
            checkOutput("model_colour", vidIf.colour, ec);
            checkOutput("model_frame_start", vidIf.frame_start, (mIdx == 0) ? 1 : 0);
            checkOutput("model_frame_count", frameCount, mFrames);
            mLastX = ex; mLastY = ey; mLastC = ec;
            mIdx++;
            if (mIdx == NPIX) begin
                mIdx = 0;
                mFrames = (mFrames + 1) % 65536;
                bounceStep(mPosX, mDirNegX, W, int'(objSize), int'(speed));
                bounceStep(mPosY, mDirNegY, H, int'(objSize), int'(speed));
            end
        end else begin
            checkOutput("hold_x", vidIf.x, mLastX);
            checkOutput("hold_y", vidIf.y, mLastY);
            checkOutput("hold_colour", vidIf.colour, mLastC);
            checkOutput("idle_frame_start", vidIf.frame_start, 0);
        end
    end

    task automatic runUntilLast(input int limit, inout int pulses, output bit sawLast);
        sawLast = 1'b0;
        for (int i = 0; i < limit && !sawLast; i++) begin
            tick();
            if (vidIf.pixel_en) begin
                pulses++;
                if (vidIf.x == 9'(W - 1) && vidIf.y == 8'(H - 1)) sawLast = 1'b1;
            end
        end
    endtask

    task automatic finishFrame(input string name);
        int  dummy;
        bit  sawLast;
        dummy = 0;
        runUntilLast(4 * NPIX + 20, dummy, sawLast);
        checkOutput(name, sawLast, 1);
        repeat (3) tick();
    endtask

    task automatic waitPixel(input int tx, input int ty, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * NPIX && !found; i++) begin
            if (vidIf.pixel_en && vidIf.x == 9'(tx) && vidIf.y == 8'(ty)) found = 1'b1;
            else tick();
        end
        checkOutput(name, found, 1);
    endtask

    task automatic captureFrame(output int cnt, output int minX, output int maxX,
                                output int minY, output int maxY, output bit sawLast);
        cnt = 0; minX = 999; maxX = -1; minY = 999; maxY = -1;
        sawLast = 1'b0;
        for (int i = 0; i < 2 * NPIX && !sawLast; i++) begin
            tick();
            if (vidIf.pixel_en) begin
                if (vidIf.colour == 3'b111) begin
                    cnt++;
                    if (int'(vidIf.x) < minX) minX = int'(vidIf.x);
                    if (int'(vidIf.x) > maxX) maxX = int'(vidIf.x);
                    if (int'(vidIf.y) < minY) minY = int'(vidIf.y);
                    if (int'(vidIf.y) > maxY) maxY = int'(vidIf.y);
                end
                if (vidIf.x == 9'(W - 1) && vidIf.y == 8'(H - 1)) sawLast = 1'b1;
            end
        end
    endtask

    // Hard stop in case something never terminates
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  pulses, t0, tPrev, extra;
        int  cnt, minX, maxX, minY, maxY;
        int  seqX[39], seqY[39];
        int  refX, refY;
        bit  refDX, refDY, sawLast, found;

        applyStimulus(4'd0, 6'd0, 3'd0, 3'b000, 3'b000, 1'b0);
        vidIf.waitrequest = 1'b0;
        bUpdate = 1'b0;

        // Reset state
        repeat (3) tick();
        checkOutput("reset_pixel_en", vidIf.pixel_en, 0);
        checkOutput("reset_frame_count", frameCount, 0);
        checkOutput("reset_x", vidIf.x, 0);
        resetn = 1'b1;
        repeat (2) tick();

        // Full frame, no pacing, background 010; first-pixel latency and frame period
        applyStimulus(4'd0, 6'd0, 3'd0, 3'b101, 3'b010, 1'b1);
        tick();
        checkOutput("latency_first_edge_pixel_en", vidIf.pixel_en, 0);
        tick();
        checkOutput("latency_second_edge_pixel_en", vidIf.pixel_en, 1);
        checkOutput("first_pixel_x", vidIf.x, 0);
        checkOutput("first_pixel_y", vidIf.y, 0);
        checkOutput("first_pixel_frame_start", vidIf.frame_start, 1);
        checkOutput("first_pixel_colour", vidIf.colour, 2);
        t0 = cycle;
        pulses = 1;
        runUntilLast(2 * NPIX, pulses, sawLast);
        checkOutput("frame0_last_pixel_seen", sawLast, 1);
        checkOutput("frame0_pixel_count", pulses, 384);
        tick();
        checkOutput("frame_end_gap_pixel_en", vidIf.pixel_en, 0);
        checkOutput("frame_count_after_frame0", frameCount, 1);
        tick();
        checkOutput("frame1_origin_frame_start", vidIf.frame_start, 1);
        checkOutput("frame_period_cycles", cycle - t0, 385);

        // Drop enable mid-frame: the frame still completes, then the block idles
        pulses = 1;
        runUntilLast(50, pulses, sawLast);
        enable = 1'b0;
        runUntilLast(2 * NPIX, pulses, sawLast);
        checkOutput("frame1_completes_after_disable", pulses, 384);
        extra = 0;
        repeat (20) begin
            tick();
            if (vidIf.pixel_en) extra++;
        end
        checkOutput("idle_after_disable_pixels", extra, 0);
        checkOutput("frame_count_after_frame1", frameCount, 2);

        // Pacing: pace_div=3 gives one pixel every 4 cycles
        applyStimulus(4'd3, 6'd0, 3'd0, 3'b101, 3'b010, 1'b1);
        tick();
        tick();
        checkOutput("pace_first_pixel_en", vidIf.pixel_en, 1);
        tPrev = cycle;
        for (int k = 1; k <= 5; k++) begin
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                tick();
                if (vidIf.pixel_en) found = 1'b1;
            end
            checkOutput("pace_pixel_seen", found, 1);
            checkOutput("pace_interval", cycle - tPrev, 4);
            checkOutput("pace_x_step", vidIf.x, k);
            tPrev = cycle;
        end
        enable = 1'b0;
        finishFrame("pace_frame_completes");

        // Stall for 10 cycles with (5,0) pending
        applyStimulus(4'd0, 6'd0, 3'd0, 3'b101, 3'b010, 1'b1);
        waitPixel(4, 0, "stall_reach_pixel_4_0");
        vidIf.waitrequest = 1'b1;
        extra = 0;
        repeat (10) begin
            tick();
            if (vidIf.pixel_en) extra++;
        end
        checkOutput("stall_no_pixel_en", extra, 0);
        vidIf.waitrequest = 1'b0;
        tick();
        checkOutput("stall_release_pixel_en", vidIf.pixel_en, 1);
        checkOutput("stall_release_x", vidIf.x, 5);
        tick();
        checkOutput("stall_next_x", vidIf.x, 6);
        enable = 1'b0;
        finishFrame("stall_frame_completes");

        // Object 8x8, speed 4, colour 111 on black, two frames
        applyStimulus(4'd0, 6'd8, 3'd4, 3'b111, 3'b000, 1'b1);
        captureFrame(cnt, minX, maxX, minY, maxY, sawLast);
        checkOutput("obj_frame0_done", sawLast, 1);
        checkOutput("obj_frame0_count", cnt, 64);
        checkOutput("obj_frame0_min_x", minX, 0);
        checkOutput("obj_frame0_max_x", maxX, 7);
        checkOutput("obj_frame0_min_y", minY, 0);
        checkOutput("obj_frame0_max_y", maxY, 7);
        tick();
        enable = 1'b0;
        captureFrame(cnt, minX, maxX, minY, maxY, sawLast);
        checkOutput("obj_frame1_done", sawLast, 1);
        checkOutput("obj_frame1_count", cnt, 64);
        checkOutput("obj_frame1_min_x", minX, 4);
        checkOutput("obj_frame1_max_x", maxX, 11);
        checkOutput("obj_frame1_min_y", minY, 4);
        checkOutput("obj_frame1_max_y", maxY, 11);
        repeat (3) tick();

        // Reset in the middle of a frame
        enable = 1'b1;
        waitPixel(10, 5, "reset_reach_pixel_10_5");
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_pixel_en", vidIf.pixel_en, 0);
        checkOutput("midreset_xy", {vidIf.x, vidIf.y}, 0);
        checkOutput("midreset_frame_count", frameCount, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("postreset_first_edge_pixel_en", vidIf.pixel_en, 0);
        tick();
        checkOutput("postreset_pixel_en", vidIf.pixel_en, 1);
        checkOutput("postreset_frame_start", vidIf.frame_start, 1);
        checkOutput("postreset_xy", {vidIf.x, vidIf.y}, 0);
        checkOutput("postreset_frame_count", frameCount, 0);
        checkOutput("postreset_colour_obj_at_origin", vidIf.colour, 7);
        enable = 1'b0;
        finishFrame("postreset_frame_completes");

        // Full-size bounce axes, size 63, speed 7
        refX = 0; refY = 0; refDX = 1'b0; refDY = 1'b0;
        seqX[0] = int'(bPosX);
        seqY[0] = int'(bPosY);
        bUpdate = 1'b1;
        for (int n = 1; n <= 38; n++) begin
            tick();
            bounceStep(refX, refDX, 320, 63, 7);
            bounceStep(refY, refDY, 240, 63, 7);
            seqX[n] = int'(bPosX);
            seqY[n] = int'(bPosY);
            checkOutput("bounce_x_model", seqX[n], refX);
            checkOutput("bounce_y_model", seqY[n], refY);
        end
        bUpdate = 1'b0;
        checkOutput("bounce_x_35", seqX[35], 245);
        checkOutput("bounce_x_36", seqX[36], 252);
        checkOutput("bounce_x_37", seqX[37], 257);
        checkOutput("bounce_x_38", seqX[38], 250);
        checkOutput("bounce_y_24", seqY[24], 168);
        checkOutput("bounce_y_25", seqY[25], 175);
        checkOutput("bounce_y_26", seqY[26], 177);
        checkOutput("bounce_y_27", seqY[27], 170);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_video_source.md
PATTERN_VIDEO_SOURCE -- requirements
Module: pattern_video_source

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low; ports named clock and resetn.
REQ-002 Parameter IMAGE_W, default 320, raster width in pixels.
REQ-003 Parameter IMAGE_H, default 240, raster height in lines.
REQ-004 clock  in  1  system clock, 50 MHz domain.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  run request, sampled only in IDLE and FRAME_END.
REQ-007 waitrequest  in  1  sink stall; no pixel is emitted while high.
REQ-008 pace_div  in  4  idle clocks between emitted pixels.
REQ-009 obj_size  in  6  square object edge in pixels; 0 means no object.
REQ-010 speed  in  3  object displacement per frame, per axis.
REQ-011 obj_colour  in  3  object colour {r,g,b}.
REQ-012 bg_colour  in  3  background colour {r,g,b}.
REQ-013 pixel_en  out  1  one-cycle strobe; x, y and colour are valid in the same cycle.
REQ-014 x  out  9  pixel column, 0..IMAGE_W-1.
REQ-015 y  out  8  pixel row, 0..IMAGE_H-1.
REQ-016 colour  out  3  pixel colour.
REQ-017 frame_start  out  1  high together with the pixel_en of pixel (0,0) only.
REQ-018 frame_count  out  16  completed frames; wraps 65535->0.

Function
REQ-019 The block SHALL use the states IDLE, EMIT, PACE and FRAME_END.
- IDLE->EMIT when enable=1; input settings are latched on that edge.
- EMIT->PACE after an emission if pace_div>0; otherwise it stays in EMIT.
- PACE->EMIT after exactly pace_div cycles.
- Emission of (IMAGE_W-1,IMAGE_H-1)->FRAME_END.
- FRAME_END lasts one cycle, then goes to EMIT if enable=1, else IDLE.
REQ-020 In EMIT, pixel_en SHALL be 1 iff waitrequest=0; while stalled, the pending pixel is held with no skip and no duplicate.
REQ-021 The first pixel_en SHALL occur on the second rising edge after the edge sampling enable=1 in IDLE.
REQ-022 Raster order SHALL be x-major: x increments, wraps to 0 at IMAGE_W-1 and increments y; no wrap occurs past the last pixel.
REQ-023 With pace_div=0 and no stall, the frame period SHALL be IMAGE_W*IMAGE_H+1 cycles.
REQ-024 colour SHALL be obj_colour iff obj_x<=x<obj_x+size and obj_y<=y<obj_y+size; otherwise it is bg_colour.
REQ-025 obj_size, speed, obj_colour and bg_colour SHALL be relatched only in FRAME_END, so every frame is internally consistent.
REQ-026 In FRAME_END, frame_count SHALL increment and each axis SHALL update, using 10-bit arithmetic:
- dir+ : if pos+speed+size>LIMIT, then pos<=LIMIT-size and dir<=-; else pos<=pos+speed.
- dir- : if pos<speed, then pos<=0 and dir<=+; else pos<=pos-speed.
- LIMIT is IMAGE_W for the x axis and IMAGE_H for the y axis.
REQ-027 Dropping enable mid-frame SHALL let the current frame complete before the block returns to IDLE.
REQ-028 Outputs SHALL be registered, and x/y/colour SHALL hold their last values while pixel_en=0.

Reset
REQ-029 While resetn=0, the following SHALL hold, asynchronously:
- pixel_en, frame_start, x, y, colour and frame_count are 0.
- state is IDLE.
- object position is (0,0), with both directions +.
REQ-030 A reset mid-frame SHALL abandon the frame, and the next frame SHALL start at (0,0) with frame_count=0.

Structure
REQ-031 IMAGE_W, IMAGE_H, X_WIDTH (9), Y_WIDTH (8) and COLOUR_WIDTH (3) SHALL live in the shared project package used by difference_engine and display.
REQ-032 Per-axis bounce logic SHALL be one sub-module, bounce_axis (parameter LIMIT), instantiated twice.

Verification
REQ-033 Full frame, settings pace_div=0, waitrequest=0, obj_size=0, bg=010:
- Exactly 76800 pixel_en pulses; first (0,0) with frame_start, last (319,239).
- All colours are 010.
- frame_count=1 one cycle later; the next (0,0) follows 76801 cycles after the previous one.
REQ-034 Pacing, pace_div=3: pixel_en every 4th cycle, x stepping 0,1,2,...
REQ-035 Stall, waitrequest high for 10 cycles with (5,0) pending: no pixel_en during the stall; (5,0) is emitted once on the first low cycle, then (6,0).
REQ-036 Object, settings obj_size=8, speed=4, obj_colour=111, bg=000:
- Frame 0: exactly 64 pixels of colour 111, covering x,y in 0..7.
- Frame 1: the object spans 4..11 on both axes.
REQ-037 Bounce, settings size=63, speed=7:
- x sequence ...,245,252,257,250.
- y sequence ...,168,175,177,170.
REQ-038 Mid-frame reset, resetn=0 at pixel (100,50): all outputs are 0 in the same cycle; after release with enable=1, pixel (0,0) arrives with frame_start and frame_count=0.
